hit_judge: RTL

HIT_JUDGE -- requirements
Module: hit_judge

---
 rtl/hit_judge_pkg.sv | 24 ++
 rtl/key_sync_debounce.sv | 46 ++++
 rtl/hit_judge.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hit_judge_pkg.sv
// Shared definitions for the hit judge: lane count, parameter defaults,
// judge FSM encoding and a lane-to-one-hot helper.
package hit_judge_pkg;

  localparam int unsigned NUM_LANES               = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 250000;
  localparam int unsigned MAX_MISSES_DEFAULT      = 3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArmed  = 2'd1,
    StJudged = 2'd2,
    StOver   = 2'd3
  } judge_state_e;

  // One-hot key pattern that a correct single-key press must match.
  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [1:0] lane);
    logic [NUM_LANES-1:0] oh;
    oh       = '0;
    oh[lane] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/key_sync_debounce.sv
// Per-key front end: 2-flop synchronizer, falling-edge detect on the
// active-low button, and a lockout counter that swallows bounce edges.
module key_sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [1:0]      sync_q;
  logic            prev_q;
  logic [CntW-1:0] lock_q;
  logic            fall;

  // Synchronize the button and keep one older sample for edge detection.
  // All flops clear to 0, so no falling edge can appear until a real high
  // sample has passed through both synchronizer stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      prev_q <= sync_q[1];
    end
  end

  assign fall  = prev_q & ~sync_q[1];
  assign press = fall & (lock_q == '0);

  // Lockout: reload on an accepted press, then count down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= '0;
    end else if (press) begin
      lock_q <= CntW'(DEBOUNCE_CYCLES);
    end else if (lock_q != '0) begin
      lock_q <= lock_q - CntW'(1);
    end
  end

endmodule

// File: rtl/hit_judge.sv
// Rhythm-game hit judge: synchronizes the beat clock and keys, latches the
// beat's target, judges the first press of each beat and publishes the
// result one beat later alongside a saturating miss counter.
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned MAX_MISSES      = MAX_MISSES_DEFAULT
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 game_clock,
  input  logic                 running,
  input  logic [NUM_LANES-1:0] KEY,
  input  logic [1:0]           target_lane,
  input  logic                 target_valid,
  output logic                 correct_key_pressed,
  output logic [1:0]           miss_count,
  output logic                 game_over,
  output logic [NUM_LANES-1:0] LEDR
);

  localparam logic [1:0] MissMax = 2'(MAX_MISSES);

  logic [NUM_LANES-1:0] press;
  logic [1:0]           gc_sync_q;
  logic                 gc_prev_q;
  logic                 beat;

  judge_state_e         state_q, state_d;
  logic [1:0]           lane_q, lane_d;
  logic                 valid_q, valid_d;
  logic                 pressed_q, pressed_d;
  logic                 hit_q, hit_d;
  logic                 ckp_q, ckp_d;
  logic [1:0]           miss_q, miss_d;
  logic [NUM_LANES-1:0] led_q, led_d;

  logic                 any_press;
  logic [1:0]           eff_lane;
  logic                 eff_valid;
  logic                 press_hit;
  logic                 ending_miss;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_key
    key_sync_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk  (CLOCK_50),
      .rst  (reset),
      .key_n(KEY[g]),
      .press(press[g])
    );
  end

  // Synchronize the beat clock; a beat boundary is its synchronized rising edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      gc_sync_q <= 2'b00;
      gc_prev_q <= 1'b0;
    end else begin
      gc_sync_q <= {gc_sync_q[0], game_clock};
      gc_prev_q <= gc_sync_q[1];
    end
  end

  assign beat      = gc_sync_q[1] & ~gc_prev_q;
  assign any_press = |press;
  // A press coinciding with a boundary belongs to the beat that is starting.
  assign eff_lane    = beat ? target_lane  : lane_q;
  assign eff_valid   = beat ? target_valid : valid_q;
  assign press_hit   = eff_valid && (press == lane_onehot(eff_lane));
  assign ending_miss = pressed_q ? ~hit_q : valid_q;

  // Judge FSM next-state, beat bookkeeping and output register inputs.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    valid_d   = valid_q;
    pressed_d = pressed_q;
    hit_d     = hit_q;
    ckp_d     = ckp_q;
    miss_d    = miss_q;
    led_d     = led_q;

    unique case (state_q)
      StIdle: begin
        ckp_d = 1'b0;
        if (running && beat) begin
          state_d   = StArmed;
          lane_d    = target_lane;
          valid_d   = target_valid;
          pressed_d = 1'b0;
          hit_d     = 1'b0;
          if (any_press) begin
            state_d   = StJudged;
            pressed_d = 1'b1;
            hit_d     = press_hit;
            led_d     = press;
          end
        end
      end

      StArmed, StJudged: begin
        if (!running) begin
          // Leaving the game drops any half-finished beat without scoring it.
          state_d   = StIdle;
          ckp_d     = 1'b0;
          pressed_d = 1'b0;
          hit_d     = 1'b0;
        end else begin
          if (beat) begin
            ckp_d = pressed_q & hit_q;
            if (ending_miss && (miss_q < MissMax)) begin
              miss_d = miss_q + 2'd1;
            end
            lane_d    = target_lane;
            valid_d   = target_valid;
            pressed_d = 1'b0;
            hit_d     = 1'b0;
            state_d   = StArmed;
          end
          if (any_press) begin
            led_d = press;
            if (state_d == StArmed) begin
              state_d   = StJudged;
              pressed_d = 1'b1;
              hit_d     = press_hit;
            end
          end
          if (miss_d == MissMax) begin
            state_d = StOver;
            ckp_d   = 1'b0;
          end
        end
      end

      StOver: begin
        ckp_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything at once.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      lane_q    <= 2'd0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
      hit_q     <= 1'b0;
      ckp_q     <= 1'b0;
      miss_q    <= 2'd0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      valid_q   <= valid_d;
      pressed_q <= pressed_d;
      hit_q     <= hit_d;
      ckp_q     <= ckp_d;
      miss_q    <= miss_d;
      led_q     <= led_d;
    end
  end

  assign correct_key_pressed = ckp_q;
  assign miss_count          = miss_q;
  assign game_over           = (state_q == StOver);
  assign LEDR                = led_q;

endmodule
